// File: rtl/rc_pkg.sv
// Shared definitions for the run checker: state encoding, the default
// result address (kept in step with the program linker script) and a
// counter-width helper.
package rc_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_RST  = 3'd0,
        S_RUN  = 3'd1,
        S_PASS = 3'd2,
        S_FAIL = 3'd3,
        S_TOUT = 3'd4
    } state_t;

    localparam logic [31:0] RC_RESULT_ADDR = 32'h0000_0010;

    // Bits needed to count from 0 up to maxval inclusive (at least 1).
    function automatic int cnt_width(input int maxval);
        return (maxval < 2) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/rc_cycle_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Clear has priority over enable; the count sticks at all-ones.
module rc_cycle_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count up while enabled, never wrapping past all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && (count != '1))
            count <= count + W'(1);
    end

endmodule

// File: rtl/run_checker.sv
// Run controller for core simulation / bring-up: holds the core in reset
// for RST_CYCLES, then watches data-memory stores and declares PASS/FAIL
// at the WRITE_IDX-th store to RESULT_ADDR, or TIMEOUT when the run-cycle
// budget is spent. All outputs come from registers.
module run_checker
    import rc_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                RST_CYCLES  = 2,
    parameter int                TIMEOUT     = 100,
    parameter logic [ADDR_W-1:0] RESULT_ADDR = ADDR_W'(RC_RESULT_ADDR),
    parameter int                WRITE_IDX   = 1,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] exp_value,
    output logic              core_rst,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [DATA_W-1:0] result,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout
);

    localparam int RW = cnt_width(RST_CYCLES);
    localparam int HW = cnt_width(WRITE_IDX);

    localparam logic [RW-1:0]    RST_LAST = RW'(RST_CYCLES - 1);
    localparam logic [HW-1:0]    HIT_LAST = HW'(WRITE_IDX - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(TIMEOUT - 1);

    state_t          state, state_nxt;
    logic [RW-1:0]   rst_cnt;
    logic [HW-1:0]   hit_cnt;
    logic            in_rst, in_run;
    logic            qual, decide, tout_hit;

    assign in_rst   = (state == S_RST);
    assign in_run   = (state == S_RUN);
    // Full-width compare: aliased addresses must not count as hits.
    assign qual     = mem_we && (mem_addr == RESULT_ADDR);
    assign decide   = in_run && qual && (hit_cnt == HIT_LAST);
    // A deciding store in the last budget cycle still wins over timeout.
    assign tout_hit = in_run && !decide && (cycle_count == RUN_LAST);

    // Reset-phase length counter; parked at zero outside S_RST.
    rc_cycle_counter #(.W(RW)) u_rst_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (restart || !in_rst),
        .en    (in_rst),
        .count (rst_cnt)
    );

    // Run-cycle counter; freezes on the edge that enters a terminal state.
    rc_cycle_counter #(.W(CNT_W)) u_cyc_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (restart || in_rst),
        .en    (in_run && !decide && !tout_hit),
        .count (cycle_count)
    );

    // Count of qualifying stores seen during this run.
    rc_cycle_counter #(.W(HW)) u_hit_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (restart || in_rst),
        .en    (in_run && qual),
        .count (hit_cnt)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_RST;
        else
            state <= state_nxt;
    end

    // Next-state: restart overrides everything, terminal states are sticky.
    always_comb begin
        state_nxt = state;
        if (restart) begin
            state_nxt = S_RST;
        end else begin
            case (state)
                S_RST:   if (rst_cnt == RST_LAST) state_nxt = S_RUN;
                S_RUN: begin
                    if (decide)
                        state_nxt = (mem_wdata == exp_value) ? S_PASS : S_FAIL;
                    else if (tout_hit)
                        state_nxt = S_TOUT;
                end
                S_PASS:  state_nxt = S_PASS;
                S_FAIL:  state_nxt = S_FAIL;
                S_TOUT:  state_nxt = S_TOUT;
                default: state_nxt = S_RST;
            endcase
        end
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        core_rst = in_rst;
        pass     = (state == S_PASS);
        fail     = (state == S_FAIL);
        timeout  = (state == S_TOUT);
        done     = (state == S_PASS) || (state == S_FAIL) || (state == S_TOUT);
    end

    // Capture the deciding store's data; cleared whenever a run restarts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            result <= '0;
        else if (restart || in_rst)
            result <= '0;
        else if (decide)
            result <= mem_wdata;
    end

endmodule

// File: tb/tb_run_checker.sv
// Bench for run_checker: two instances share one stimulus stream, one
// checking the 10th store and one the 1st. Fixed scenarios come from a
// table with hand-derived expectations; random scenarios are judged by a
// store-list reference model.
module tb_run_checker;

    localparam int TO   = 100;
    localparam int NCYC = TO + 5;
    localparam logic [31:0] RA = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        reset, restart, mem_we;
    logic [31:0] mem_addr, mem_wdata, exp_value;

    logic        core_rst_a, done_a, pass_a, fail_a, timeout_a;
    logic [15:0] cc_a;
    logic [31:0] result_a;
    logic        core_rst_b, done_b, pass_b, fail_b, timeout_b;
    logic [15:0] cc_b;
    logic [31:0] result_b;

    always #5 clk = ~clk;

    run_checker #(.DATA_W(32), .ADDR_W(32), .RST_CYCLES(3), .TIMEOUT(TO),
                  .RESULT_ADDR(RA), .WRITE_IDX(10), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .restart(restart), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .exp_value(exp_value),
        .core_rst(core_rst_a), .cycle_count(cc_a), .result(result_a),
        .done(done_a), .pass(pass_a), .fail(fail_a), .timeout(timeout_a));

    run_checker #(.DATA_W(32), .ADDR_W(32), .RST_CYCLES(3), .TIMEOUT(TO),
                  .RESULT_ADDR(RA), .WRITE_IDX(1), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .restart(restart), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .exp_value(exp_value),
        .core_rst(core_rst_b), .cycle_count(cc_b), .result(result_b),
        .done(done_b), .pass(pass_b), .fail(fail_b), .timeout(timeout_b));

    // Outcome codes: 1 pass, 2 fail, 3 timeout.
    typedef struct {
        string       nm;
        int          n, first, gap;
        logic [31:0] addr;
        logic        we;
        logic [31:0] expv;
        int          a_code; logic [31:0] a_res; int a_cc;
        int          b_code; logic [31:0] b_res; int b_cc;
    } scen_t;

    scen_t       tbl[7];
    logic        we_at  [NCYC];
    logic [31:0] addr_at[NCYC];
    logic [31:0] data_at[NCYC];
    logic [31:0] exp_at [NCYC];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    function automatic scen_t mk(input string nm, input int n, input int first, input int gap,
                                 input logic [31:0] addr, input logic we, input logic [31:0] expv,
                                 input int ac, input logic [31:0] ar, input int acc,
                                 input int bc, input logic [31:0] br, input int bcc);
        scen_t s;
        s.nm = nm; s.n = n; s.first = first; s.gap = gap; s.addr = addr; s.we = we; s.expv = expv;
        s.a_code = ac; s.a_res = ar; s.a_cc = acc;
        s.b_code = bc; s.b_res = br; s.b_cc = bcc;
        return s;
    endfunction

    function automatic logic [3:0] flags_of(input int code);
        case (code)
            1:       return 4'b1100;
            2:       return 4'b1010;
            3:       return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    // Reference: walk the store list within the budget, counting hits.
    function automatic void model(input int wi, output int code, output logic [31:0] res,
                                  output int cc);
        int  hits = 0;
        bit  found = 0;
        code = 3; res = '0; cc = TO - 1;
        for (int c = 0; c < TO; c++) begin
            if (!found && we_at[c] && addr_at[c] == RA) begin
                hits++;
                if (hits == wi) begin
                    found = 1;
                    res   = data_at[c];
                    code  = (data_at[c] == exp_at[c]) ? 1 : 2;
                    cc    = c;
                end
            end
        end
    endfunction

    // Store i (0-based) lands at cycle first+i*gap with running sum 1+..+(i+1).
    task automatic load_scen(input scen_t s);
        for (int c = 0; c < NCYC; c++) begin
            we_at[c] = 1'b0; addr_at[c] = '0; data_at[c] = '0; exp_at[c] = s.expv;
        end
        for (int i = 0; i < s.n; i++) begin
            int c;
            c = s.first + i * s.gap;
            if (c < NCYC) begin
                we_at[c] = s.we; addr_at[c] = s.addr; data_at[c] = 32'((i + 1) * (i + 2) / 2);
            end
        end
    endtask

    task automatic load_random(input int dens);
        for (int c = 0; c < NCYC; c++) begin
            we_at[c] = ($urandom_range(99) < dens);
            case ($urandom_range(2))
                0:       addr_at[c] = RA;
                1:       addr_at[c] = RA ^ (32'd1 << $urandom_range(31));
                default: addr_at[c] = $urandom;
            endcase
            if ($urandom_range(1) == 0) addr_at[c] = RA;
            data_at[c] = 32'($urandom_range(3));
            exp_at[c]  = 32'($urandom_range(3));
        end
    endtask

    // Count edges until core_rst drops, bounded.
    task automatic count_rst(input string nm);
        int n = 0;
        while (core_rst_a === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_rst_edges"}, 64'(n), 64'd3);
        chk({nm, "_rst_b"}, 64'(core_rst_b), 64'd0);
    endtask

    task automatic do_restart(input string nm);
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk({nm, "_rs_state"}, {core_rst_a, done_a, pass_a, fail_a, timeout_a,
                                core_rst_b, done_b, pass_b, fail_b, timeout_b}, 64'b10000_10000);
        chk({nm, "_rs_cnt"}, {cc_a, cc_b}, 64'd0);
        chk({nm, "_rs_res"}, {result_a, result_b}, 64'd0);
        count_rst(nm);
    endtask

    task automatic run_and_check(input string nm, input int ac, input logic [31:0] ar, input int acc,
                                 input int bc, input logic [31:0] br, input int bcc);
        int first_a = -1, first_b = -1;
        chk({nm, "_cc0"}, {cc_a, cc_b}, 64'd0);
        for (int c = 0; c < NCYC; c++) begin
            mem_we = we_at[c]; mem_addr = addr_at[c]; mem_wdata = data_at[c]; exp_value = exp_at[c];
            @(negedge clk);
            if (first_a < 0 && done_a) first_a = c + 1;
            if (first_b < 0 && done_b) first_b = c + 1;
        end
        mem_we = 1'b0;
        chk({nm, "_a_flags"}, {done_a, pass_a, fail_a, timeout_a}, flags_of(ac));
        chk({nm, "_a_result"}, result_a, ar);
        chk({nm, "_a_cc"}, cc_a, 64'(acc));
        chk({nm, "_a_latency"}, 64'(first_a), 64'(acc + 1));
        chk({nm, "_a_rst"}, core_rst_a, 64'd0);
        chk({nm, "_b_flags"}, {done_b, pass_b, fail_b, timeout_b}, flags_of(bc));
        chk({nm, "_b_result"}, result_b, br);
        chk({nm, "_b_cc"}, cc_b, 64'(bcc));
        chk({nm, "_b_latency"}, 64'(first_b), 64'(bcc + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = mk("sum10",   10,  2, 3, RA,            1'b1, 32'd55, 1, 32'd55, 29, 2, 32'd1,  2);
        tbl[1] = mk("rerun",   10,  2, 3, RA,            1'b1, 32'd55, 1, 32'd55, 29, 2, 32'd1,  2);
        tbl[2] = mk("addr_hi", 10,  2, 3, 32'h1000_0010, 1'b1, 32'd55, 3, 32'd0,  99, 3, 32'd0,  99);
        tbl[3] = mk("we_low",  10,  0, 1, RA,            1'b0, 32'd55, 3, 32'd0,  99, 3, 32'd0,  99);
        tbl[4] = mk("edge99",  10, 72, 3, RA,            1'b1, 32'd55, 1, 32'd55, 99, 2, 32'd1,  72);
        tbl[5] = mk("exp1",    10,  0, 1, RA,            1'b1, 32'd1,  2, 32'd55, 9,  1, 32'd1,  0);
        tbl[6] = mk("late",    10, 73, 3, RA,            1'b1, 32'd55, 3, 32'd0,  99, 2, 32'd1,  73);

        reset = 1'b0; restart = 1'b0; mem_we = 1'b0;
        mem_addr = '0; mem_wdata = '0; exp_value = '0;
        #12;
        chk("por_state", {core_rst_a, done_a, pass_a, fail_a, timeout_a,
                          core_rst_b, done_b, pass_b, fail_b, timeout_b}, 64'b10000_10000);
        chk("por_cnt", {cc_a, cc_b}, 64'd0);
        chk("por_res", {result_a, result_b}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        count_rst("por");

        for (int i = 0; i < 7; i++) begin
            load_scen(tbl[i]);
            do_restart(tbl[i].nm);
            run_and_check(tbl[i].nm, tbl[i].a_code, tbl[i].a_res, tbl[i].a_cc,
                          tbl[i].b_code, tbl[i].b_res, tbl[i].b_cc);
        end

        for (int r = 0; r < 6; r++) begin
            int ac, acc, bc, bcc;
            logic [31:0] ar, br;
            load_random((r % 2 == 0) ? 45 : 8);
            model(10, ac, ar, acc);
            model(1, bc, br, bcc);
            do_restart($sformatf("rand%0d", r));
            run_and_check($sformatf("rand%0d", r), ac, ar, acc, bc, br, bcc);
        end

        // Asynchronous reset in the middle of a run, then a clean rerun.
        load_scen(tbl[0]);
        do_restart("async");
        for (int c = 0; c < 40; c++) begin
            mem_we = we_at[c]; mem_addr = addr_at[c]; mem_wdata = data_at[c]; exp_value = exp_at[c];
            @(negedge clk);
        end
        mem_we = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_state", {core_rst_a, done_a, pass_a, fail_a, timeout_a,
                            core_rst_b, done_b, pass_b, fail_b, timeout_b}, 64'b10000_10000);
        chk("async_cnt", {cc_a, cc_b}, 64'd0);
        chk("async_res", {result_a, result_b}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        count_rst("async_rel");
        run_and_check("async_rerun", 1, 32'd55, 29, 2, 32'd1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/run_checker.md
# run_checker

Self-checking run controller for single-cycle core simulations and FPGA bring-up. It sits beside the core in the test top and drives the core's reset for a programmable number of cycles. It then snoops the core's data-memory write port and counts run cycles. It declares PASS, FAIL or TIMEOUT when the Nth store to a designated result address arrives or a cycle budget expires, replacing the free-running clock-and-finish bench of the previous generation.

## Interface
Parameters:
- DATA_W, 32, width of store data and expected value
- ADDR_W, 32, width of store address
- RST_CYCLES, 2, cycles core_rst is held after reset release (>=1)
- TIMEOUT, 100, run-cycle budget (>=1); 100 cycles matches 1000 ns at 10 ns clock
- RESULT_ADDR, 32'h0000_0010, byte address of the result store
- WRITE_IDX, 1, which store to RESULT_ADDR is checked (1 = first); earlier stores are intermediate
- CNT_W, 16, width of cycle counter (must hold TIMEOUT)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; low forces all state to reset values
- restart  in  1  synchronous pulse; re-enters reset sequence from any state
- mem_we  in  1  core data-memory write enable
- mem_addr  in  ADDR_W  core data-memory address
- mem_wdata  in  DATA_W  core store data
- exp_value  in  DATA_W  expected result; sampled only at the deciding store
- core_rst  out  1  active-high reset to core
- cycle_count  out  CNT_W  run cycles elapsed
- result  out  DATA_W  data of the deciding store (0 on timeout)
- done  out  1  sticky; any terminal state reached
- pass, fail, timeout  out  1 each  sticky, one-hot when done=1

## Operation
- States: S_RST, S_RUN, S_PASS, S_FAIL, S_TOUT.
- Reset values: state=S_RST, core_rst=1, cycle_count=0, result=0, done/pass/fail/timeout=0, internal rst_cnt=0, hit_cnt=0.
- S_RST: core_rst=1; rst_cnt increments per cycle; when rst_cnt==RST_CYCLES-1 go to S_RUN, clear cycle_count and hit_cnt.
- S_RUN: core_rst=0; cycle_count increments per cycle. Qualifying store = mem_we && mem_addr==RESULT_ADDR; it increments hit_cnt.
- When a qualifying store makes hit_cnt reach WRITE_IDX, latch result=mem_wdata and go to S_PASS if mem_wdata==exp_value, else S_FAIL.
- If cycle_count==TIMEOUT-1 and no deciding store that cycle, go to S_TOUT; result stays 0.
- Simultaneous deciding store and timeout: store wins (PASS/FAIL).
- Stores to other addresses, or with mem_we=0, are ignored; address compare is full width, with no masking.
- Terminal states are sticky and hold core_rst=0. cycle_count freezes and the core keeps running; later stores are ignored.
- restart=1 in any state returns to S_RST at the next edge: flags, result, counters cleared, core_rst=1. restart has priority over every other transition.
- Async reset mid-run: immediate return to reset values; sequence restarts on release.
- cycle_count saturates at its maximum and never wraps.

## Timing
- After reset deasserts, core_rst stays 1 for exactly RST_CYCLES rising edges, then drops (registered output).
- The first S_RUN cycle has cycle_count=0; the core executes its first instruction in that cycle.
- Deciding store sampled at edge k → state/flags/result visible after edge k (1-cycle latency, registered outputs).
- Timeout: flag visible after the TIMEOUT-th run edge.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Shared package rc_pkg: state enum (S_RST, S_RUN, S_PASS, S_FAIL, S_TOUT) and state encoding width. Default RESULT_ADDR is a constant here so the program linker script and checker agree.
- Single module. An optional sub-module, rc_cycle_counter (saturating, clearable, enable), is natural and is reused for rst_cnt and cycle_count.

## Test plan
- Sum-of-n loop (n=10), stores 1,3,6,…,55 to 0x10; WRITE_IDX=10, exp_value=55 → pass=1, result=0x37 one cycle after the 10th store.
- Same program with WRITE_IDX=1, exp_value=55 → fail=1, result=1.
- No store to 0x10, TIMEOUT=100 → timeout=1 after the 100th run edge, cycle_count=99, result=0.
- Deciding store on cycle_count=99 → pass, not timeout.
- RST_CYCLES=3: reset released at t0 → core_rst=1 for 3 edges, then 0. Async reset asserted mid-run → all outputs at reset values immediately.
- restart pulse while in S_PASS → flags clear, core_rst=1 for RST_CYCLES, rerun reaches pass again with identical cycle_count.
